// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - opcode/funct constants, ALUOp codes, FSM states and the ID/EX control bundle
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_MUL   = 6'h1c;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_MUL = 6'h02;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_BEQ  = 3'b001;
  localparam logic [2:0] ALU_R    = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_MUL  = 3'b110;

  typedef enum logic {ST_RUN, ST_MUL_WAIT} mul_state_e;

  // rsvd pads the 19 control bits to a 20-bit bundle and is always zero
  typedef struct packed {
    logic       rsvd;
    logic       valid;
    logic [1:0] PCSrc;
    logic       Branch;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] MemtoReg;
    logic       ALUSrc1;
    logic       ALUSrc2;
    logic       ExtOp;
    logic       LuOp;
    logic [3:0] ALUOp;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// rtl/pipe_ctrl_unit_decode.sv - combinational OpCode/Funct to control-bundle decoder
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output ctrl_t      ctrl
);

  logic       is_r, is_jr, is_j, is_jal, is_beq, is_lw, is_sw, is_lui, is_mul, is_shift;
  logic [2:0] alu_lo;

  always_comb begin
    is_r     = (OpCode == OP_RTYPE);
    is_jr    = is_r && (Funct == FN_JR);
    is_j     = (OpCode == OP_J);
    is_jal   = (OpCode == OP_JAL);
    is_beq   = (OpCode == OP_BEQ);
    is_lw    = (OpCode == OP_LW);
    is_sw    = (OpCode == OP_SW);
    is_lui   = (OpCode == OP_LUI);
    is_mul   = (OpCode == OP_MUL) && (Funct == FN_MUL);
    is_shift = is_r && (Funct == FN_SLL || Funct == FN_SRL || Funct == FN_SRA);

    if (is_r)                                         alu_lo = ALU_R;
    else if (is_beq)                                  alu_lo = ALU_BEQ;
    else if (OpCode == OP_ANDI)                       alu_lo = ALU_AND;
    else if (OpCode == OP_SLTI || OpCode == OP_SLTIU) alu_lo = ALU_SLT;
    else if (is_mul)                                  alu_lo = ALU_MUL;
    else                                              alu_lo = ALU_NONE;

    // valid is left clear; the top stamps it with id_valid at acceptance
    ctrl          = CTRL_BUBBLE;
    ctrl.PCSrc    = (is_j || is_jal) ? 2'b01 : (is_jr ? 2'b10 : 2'b00);
    ctrl.Branch   = is_beq;
    ctrl.RegWrite = !(is_sw || is_beq || is_j || is_jr);
    ctrl.RegDst   = (is_jr || is_sw || is_beq || is_j || is_jal) ? 2'b10 :
                    ((is_r || is_mul) ? 2'b01 : 2'b00);
    ctrl.MemRead  = is_lw;
    ctrl.MemWrite = is_sw;
    ctrl.MemtoReg = is_lw ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
    ctrl.ALUSrc1  = is_shift;
    ctrl.ALUSrc2  = !(is_r || is_mul || is_beq);
    ctrl.ExtOp    = !is_lui;
    ctrl.LuOp     = is_lui;
    ctrl.ALUOp    = {OpCode[0], alu_lo};
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - ID-stage hazard/flush control and ID/EX control register
// PIPE_CTRL_MUL_MULTI_EN enables the multicycle mul wait (MUL_WAIT state and counter).
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned RA_W    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [5:0]      OpCode,
  input  logic [5:0]      Funct,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            ex_branch_taken,
  output logic            stall,
  output logic            flush_ifid,
  output ctrl_t           ex_ctrl,
  output logic [RA_W-1:0] ex_rt,
  output logic            mul_busy
);

  if (MUL_LAT < 1 || MUL_LAT > 16) begin : g_bad_mul_lat
    $error("pipe_ctrl_unit: MUL_LAT must be within 1..16");
  end

  ctrl_t           dec, ex_ctrl_q, ex_ctrl_d;
  logic [RA_W-1:0] ex_rt_q, ex_rt_d;
  logic            load_use, mul_wait, accept, is_jump;

  ctrl_decode u_decode (
    .OpCode (OpCode),
    .Funct  (Funct),
    .ctrl   (dec)
  );

  assign is_jump  = (dec.PCSrc != 2'b00);
  assign load_use = id_valid && ex_ctrl_q.valid && ex_ctrl_q.MemRead && (ex_rt_q != '0) &&
                    (ex_rt_q == id_rs || ex_rt_q == id_rt);
  assign accept   = !mul_wait && !load_use && !ex_branch_taken;

  // a taken branch squashes IF/ID, so it also releases any stall request
  assign stall      = !reset && !ex_branch_taken && (mul_wait || load_use);
  assign flush_ifid = !reset && (ex_branch_taken || (accept && id_valid && is_jump));

  always_comb begin
    ex_ctrl_d = ex_ctrl_q;
    ex_rt_d   = ex_rt_q;
    if (ex_branch_taken || load_use) begin
      ex_ctrl_d = CTRL_BUBBLE;
      ex_rt_d   = '0;
    end else if (!mul_wait) begin
      ex_ctrl_d       = dec;
      ex_ctrl_d.valid = id_valid;
      ex_rt_d         = id_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl_q <= CTRL_BUBBLE;
      ex_rt_q   <= '0;
    end else begin
      ex_ctrl_q <= ex_ctrl_d;
      ex_rt_q   <= ex_rt_d;
    end
  end

`ifdef PIPE_CTRL_MUL_MULTI_EN
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);
  localparam bit         MUL_MULTI    = (MUL_LAT > 1);

  mul_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (accept && id_valid && dec.ALUOp[2:0] == ALU_MUL && MUL_MULTI) begin
          state_d = ST_MUL_WAIT;
          cnt_d   = MUL_CNT_INIT;
        end
      end
      ST_MUL_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (ex_branch_taken) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mul_wait = (state_q == ST_MUL_WAIT);
`else
  assign mul_wait = 1'b0;
`endif

  assign mul_busy = mul_wait;
  assign ex_ctrl  = ex_ctrl_q;
  assign ex_rt    = ex_rt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - self-checking bench for pipe_ctrl_unit, follows PIPE_CTRL_MUL_MULTI_EN
module tb_pipe_ctrl_unit;
  import pipe_ctrl_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int RA_W    = 5;

`ifdef PIPE_CTRL_MUL_MULTI_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, id_valid, ex_branch_taken;
  logic [5:0]      OpCode, Funct;
  logic [RA_W-1:0] id_rs, id_rt;
  logic            stall, flush_ifid, mul_busy;
  ctrl_t           ex_ctrl;
  logic [RA_W-1:0] ex_rt;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.MUL_LAT(MUL_LAT), .RA_W(RA_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .OpCode          (OpCode),
    .Funct           (Funct),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .flush_ifid      (flush_ifid),
    .ex_ctrl         (ex_ctrl),
    .ex_rt           (ex_rt),
    .mul_busy        (mul_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-instruction control table plus pipeline rules
  ctrl_t     m_ctrl;
  logic [4:0] m_rt;
  int        m_left = 0;

  function automatic ctrl_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c = '0;
    c.RegWrite = 1'b1;
    c.ALUSrc2  = 1'b1;
    c.ExtOp    = 1'b1;
    if (op == 6'h00) begin
      c.ALUSrc2 = 1'b0;
      c.ALUOp[2:0] = 3'b010;
      if (fn == 6'h08) begin
        c.PCSrc = 2'b10; c.RegWrite = 1'b0; c.RegDst = 2'b10;
      end else begin
        c.RegDst  = 2'b01;
        c.ALUSrc1 = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
      end
    end else begin
      case (op)
        6'h02: begin c.PCSrc = 2'b01; c.RegWrite = 1'b0; c.RegDst = 2'b10; end
        6'h03: begin c.PCSrc = 2'b01; c.RegDst = 2'b10; c.MemtoReg = 2'b10; end
        6'h04: begin
          c.Branch = 1'b1; c.RegWrite = 1'b0; c.RegDst = 2'b10;
          c.ALUSrc2 = 1'b0; c.ALUOp[2:0] = 3'b001;
        end
        6'h23: begin c.MemRead = 1'b1; c.MemtoReg = 2'b01; end
        6'h2b: begin c.MemWrite = 1'b1; c.RegWrite = 1'b0; c.RegDst = 2'b10; end
        6'h0f: begin c.ExtOp = 1'b0; c.LuOp = 1'b1; end
        6'h0c: c.ALUOp[2:0] = 3'b100;
        6'h0a, 6'h0b: c.ALUOp[2:0] = 3'b101;
        6'h1c: if (fn == 6'h02) begin
          c.RegDst = 2'b01; c.ALUSrc2 = 1'b0; c.ALUOp[2:0] = 3'b110;
        end
        default: ;
      endcase
    end
    c.ALUOp[3] = op[0];
    return c;
  endfunction

  function automatic ctrl_t ref_accept();
    ctrl_t c = ref_decode(OpCode, Funct);
    c.valid = id_valid;
    return c;
  endfunction

  function automatic bit exp_load_use();
    return id_valid && m_ctrl.valid && m_ctrl.MemRead && m_rt != 5'd0 &&
           (m_rt == id_rs || m_rt == id_rt);
  endfunction

  function automatic bit exp_jump();
    return OpCode == 6'h02 || OpCode == 6'h03 || (OpCode == 6'h00 && Funct == 6'h08);
  endfunction

  function automatic bit exp_stall();
    return !reset && !ex_branch_taken && (m_left > 0 || exp_load_use());
  endfunction

  function automatic bit exp_flush();
    return !reset && (ex_branch_taken ||
                      (m_left == 0 && !exp_load_use() && id_valid && exp_jump()));
  endfunction

  always @(posedge clk) begin
    if (reset || ex_branch_taken) begin
      m_ctrl <= '0;
      m_rt   <= '0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end else if (exp_load_use()) begin
      m_ctrl <= '0;
      m_rt   <= '0;
    end else begin
      m_ctrl <= ref_accept();
      m_rt   <= id_rt;
      if (MULTI && id_valid && OpCode == 6'h1c && Funct == 6'h02 && MUL_LAT > 1)
        m_left <= MUL_LAT - 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("cmp_stall", 32'(stall), 32'(exp_stall()));
      chk("cmp_flush_ifid", 32'(flush_ifid), 32'(exp_flush()));
      chk("cmp_mul_busy", 32'(mul_busy), 32'(m_left > 0));
      chk("cmp_ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
      if (m_ctrl.valid) chk("cmp_ex_rt", 32'(ex_rt), 32'(m_rt));
    end
  end

  task automatic cyc(input bit v, input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rs, input logic [4:0] rt, input bit tk = 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0; id_valid = v; OpCode = op; Funct = fn;
    id_rs = rs; id_rt = rt; ex_branch_taken = tk;
  endtask

  logic [11:0] sweep [18] = '{
    {6'h00, 6'h20}, {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h03}, {6'h00, 6'h08},
    {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h04, 6'h00}, {6'h23, 6'h00}, {6'h2b, 6'h00},
    {6'h0f, 6'h00}, {6'h0c, 6'h00}, {6'h0a, 6'h00}, {6'h0b, 6'h00}, {6'h0d, 6'h00},
    {6'h1c, 6'h02}, {6'h1c, 6'h00}, {6'h08, 6'h00}
  };

  initial begin
    reset = 1'b1; id_valid = 1'b0; OpCode = '0; Funct = '0;
    id_rs = '0; id_rt = '0; ex_branch_taken = 1'b0;
    @(posedge clk);
    armed = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_ex_ctrl", 32'(ex_ctrl), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_flush", 32'(flush_ifid), 32'd0);
    chk("reset_busy", 32'(mul_busy), 32'd0);

    // lw $t0 then add $t1,$t0,$t2
    cyc(1'b1, 6'h23, 6'h00, 5'd29, 5'd8);
    cyc(1'b1, 6'h00, 6'h20, 5'd8, 5'd10);
    #1 chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_lw_in_ex", 32'(ex_ctrl.MemRead), 32'd1);
    cyc(1'b1, 6'h00, 6'h20, 5'd8, 5'd10);
    #1 chk("lu_bubble", 32'(ex_ctrl), 32'd0);
    chk("lu_release", 32'(stall), 32'd0);
    cyc(1'b1, 6'h0d, 6'h00, 5'd1, 5'd2);
    #1 chk("add_regdst", 32'(ex_ctrl.RegDst), 32'h1);
    chk("add_aluop", 32'(ex_ctrl.ALUOp), 32'h2);
    chk("add_rt", 32'(ex_rt), 32'd10);

    // lw $zero then a use of register 0
    cyc(1'b1, 6'h23, 6'h00, 5'd29, 5'd0);
    cyc(1'b1, 6'h00, 6'h20, 5'd0, 5'd0);
    #1 chk("lw_zero_stall", 32'(stall), 32'd0);

    // jal
    cyc(1'b1, 6'h03, 6'h00, 5'd0, 5'd0);
    #1 chk("jal_flush", 32'(flush_ifid), 32'd1);
    cyc(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
    #1 chk("jal_pcsrc", 32'(ex_ctrl.PCSrc), 32'h1);
    chk("jal_memtoreg", 32'(ex_ctrl.MemtoReg), 32'h2);
    chk("jal_regdst", 32'(ex_ctrl.RegDst), 32'h2);
    chk("jal_regwrite", 32'(ex_ctrl.RegWrite), 32'd1);

    // jr invalid then valid
    cyc(1'b0, 6'h00, 6'h08, 5'd31, 5'd0);
    #1 chk("inv_jr_flush", 32'(flush_ifid), 32'd0);
    cyc(1'b1, 6'h00, 6'h08, 5'd31, 5'd0);
    #1 chk("jr_flush", 32'(flush_ifid), 32'd1);

    // invalid ID never raises load-use; a taken branch beats it
    cyc(1'b1, 6'h23, 6'h00, 5'd29, 5'd9);
    cyc(1'b0, 6'h00, 6'h20, 5'd9, 5'd9);
    #1 chk("inv_lu_stall", 32'(stall), 32'd0);
    cyc(1'b1, 6'h23, 6'h00, 5'd29, 5'd9);
    cyc(1'b1, 6'h00, 6'h20, 5'd9, 5'd9, 1'b1);
    #1 chk("br_flush", 32'(flush_ifid), 32'd1);
    chk("br_no_stall", 32'(stall), 32'd0);
    cyc(1'b1, 6'h0d, 6'h00, 5'd1, 5'd2);
    #1 chk("br_bubble", 32'(ex_ctrl), 32'd0);

    // mul followed by add
    cyc(1'b1, 6'h1c, 6'h02, 5'd3, 5'd4);
    cyc(1'b1, 6'h00, 6'h20, 5'd5, 5'd6);
`ifdef PIPE_CTRL_MUL_MULTI_EN
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("mul_stall", 32'(stall), 32'd1);
      chk("mul_busy", 32'(mul_busy), 32'd1);
      chk("mul_hold_aluop", 32'(ex_ctrl.ALUOp), 32'h6);
      @(posedge clk);
      #3;
    end
    chk("mul_done_stall", 32'(stall), 32'd0);
    chk("mul_done_busy", 32'(mul_busy), 32'd0);
    cyc(1'b1, 6'h0d, 6'h00, 5'd1, 5'd2);
    #1 chk("mul_next_aluop", 32'(ex_ctrl.ALUOp), 32'h2);
`else
    #1 chk("mul_no_stall", 32'(stall), 32'd0);
    chk("mul_aluop", 32'(ex_ctrl.ALUOp), 32'h6);
    chk("mul_no_busy", 32'(mul_busy), 32'd0);
`endif

    // taken branch in the second wait cycle
    cyc(1'b1, 6'h1c, 6'h02, 5'd3, 5'd4);
    cyc(1'b1, 6'h00, 6'h20, 5'd5, 5'd6);
    cyc(1'b1, 6'h00, 6'h20, 5'd5, 5'd6, 1'b1);
    #1 chk("abort_flush", 32'(flush_ifid), 32'd1);
    cyc(1'b1, 6'h0d, 6'h00, 5'd1, 5'd2);
    #1 chk("abort_bubble", 32'(ex_ctrl), 32'd0);
    chk("abort_busy", 32'(mul_busy), 32'd0);

    // reset in the middle of a mul wait
    cyc(1'b1, 6'h1c, 6'h02, 5'd3, 5'd4);
    cyc(1'b1, 6'h00, 6'h20, 5'd5, 5'd6);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_mid_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1 chk("rst_mid_busy", 32'(mul_busy), 32'd0);
    chk("rst_mid_ctrl", 32'(ex_ctrl), 32'd0);

    // decode sweep, checked by the per-cycle compare
    for (int i = 0; i < 18; i++) begin
      logic [11:0] e;
      e = sweep[i];
      cyc(1'b1, e[11:6], e[5:0], 5'(i + 11), 5'(i + 12));
    end
    cyc(1'b0, 6'h23, 6'h00, 5'd0, 5'd0);
    cyc(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);

    @(posedge clk);
    #1;
    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
